mem_access_ctrl: RTL and testbench

Sequencing controller for the MEM stage of the 16-bit pipeline. Issues each load/store from the EX/MEM control bits to a multi-cycle (stalling) data memory, freezes the upstream stages until the access completes, and injects bubbles into the MEM/WB pipeline register while the MEM stage is not advancing. It also holds the read data stable across external pipeline holds and flags a hung memory with a sticky timeout error.

---
 rtl/mem_ctrl_defs.sv | 21 ++
 rtl/mem_timeout_cnt.sv | 34 +++
 rtl/mem_access_ctrl.sv | 104 ++++++++++
 tb/tb_mem_access_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_defs.sv
// Shared definitions for the MEM-stage access controller: state encodings and timeout default.
// Pure declarations, no logic.
package mem_ctrl_defs;

  localparam int TIMEOUT_DEF = 15;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_REQ  = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_HOLD = 3'd3;
  localparam logic [2:0] ST_ERR  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE,
    S_REQ  = ST_REQ,
    S_WAIT = ST_WAIT,
    S_HOLD = ST_HOLD,
    S_ERR  = ST_ERR
  } state_e;

endpackage

// File: rtl/mem_timeout_cnt.sv
// Saturating cycle counter with clear priority over enable; reached_o flags the enabled
// cycle whose increment brings the count to LIMIT, so the caller can react on that same edge.
module mem_timeout_cnt
  import mem_ctrl_defs::*;
#(
  parameter int LIMIT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic reached_o
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i && cnt_q != W'(LIMIT))
      cnt_d = cnt_q + 1'b1;
  end

  assign reached_o = en_i && (({1'b0, cnt_q} + 1'b1) >= (W + 1)'(LIMIT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage sequencer: issues load/store to a stalling data memory, freezes upstream until done,
// bubbles MEM/WB while not advancing; zero stall cycles on same-cycle done, sticky error on hang.
module mem_access_ctrl
  import mem_ctrl_defs::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int DATA_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic              flush_i,
  input  logic              hold_i,
  output logic              dmem_en_o,
  output logic              dmem_wr_o,
  input  logic              dmem_stall_i,
  input  logic              dmem_done_i,
  input  logic [DATA_W-1:0] dmem_rdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              stall_o,
  output logic              memwb_bubble_o,
  output logic              err_o
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] held_q, held_d;
  logic              req, issue, complete, stall_c;
  logic              cnt_en, cnt_clr, cnt_reached;

  assign req = (mem_read_i | mem_write_i) & ~flush_i;

  always_comb begin
    state_d  = state_q;
    held_d   = held_q;
    issue    = 1'b0;
    complete = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          issue = 1'b1;
          if (dmem_stall_i)     state_d  = S_REQ;
          else if (dmem_done_i) complete = 1'b1;
          else                  state_d  = S_WAIT;
        end
      end
      S_REQ: begin
        issue = 1'b1;
        if (flush_i)
          state_d = S_IDLE;
        else if (!dmem_stall_i) begin
          if (dmem_done_i) complete = 1'b1;
          else             state_d  = S_WAIT;
        end
      end
      // The access is already committed to memory here, so a flush cannot cancel it.
      S_WAIT: complete = dmem_done_i;
      S_HOLD: if (!hold_i) state_d = S_IDLE;
      S_ERR:  state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase

    if (complete) begin
      held_d  = dmem_rdata_i;
      state_d = hold_i ? S_HOLD : S_IDLE;
    end else if (cnt_reached && state_d != S_IDLE) begin
      state_d = S_ERR;
    end

    stall_c = (state_q == S_ERR) | ((issue | (state_q == S_WAIT)) & ~complete);
  end

  assign cnt_en  = (state_q == S_REQ) || (state_q == S_WAIT);
  assign cnt_clr = (state_d == S_IDLE) || (state_d == S_HOLD);

  mem_timeout_cnt #(
    .LIMIT(TIMEOUT)
  ) u_timeout_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (cnt_clr),
    .en_i     (cnt_en),
    .reached_o(cnt_reached)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      held_q  <= '0;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
    end
  end

  // Outputs are gated by reset so nothing leaks out while rst is low, whatever the inputs do.
  assign dmem_en_o      = rst & issue;
  assign dmem_wr_o      = rst & issue & mem_write_i & ~mem_read_i;
  assign stall_o        = rst & stall_c;
  assign memwb_bubble_o = rst & (stall_c | hold_i);
  assign err_o          = rst & (state_q == S_ERR);
  assign rdata_o        = !rst ? '0 : (dmem_done_i ? dmem_rdata_i : held_q);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized scoreboard bench for mem_access_ctrl plus directed flush, timeout and reset cases.
module tb_mem_access_ctrl;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read_i, mem_write_i, flush_i, hold_i;
  logic        dmem_en_o, dmem_wr_o, dmem_stall_i, dmem_done_i;
  logic [15:0] dmem_rdata_i, rdata_o;
  logic        stall_o, memwb_bubble_o, err_o;

  always #5 clk = ~clk;

  mem_access_ctrl #(.TIMEOUT(TO), .DATA_W(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_read_i    (mem_read_i),
    .mem_write_i   (mem_write_i),
    .flush_i       (flush_i),
    .hold_i        (hold_i),
    .dmem_en_o     (dmem_en_o),
    .dmem_wr_o     (dmem_wr_o),
    .dmem_stall_i  (dmem_stall_i),
    .dmem_done_i   (dmem_done_i),
    .dmem_rdata_i  (dmem_rdata_i),
    .rdata_o       (rdata_o),
    .stall_o       (stall_o),
    .memwb_bubble_o(memwb_bubble_o),
    .err_o         (err_o)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One expected access: direction, memory stall cycles before acceptance, wait cycles
  // from acceptance to done, whether hold_i is high at completion, and the returned data.
  typedef struct {
    logic        wr;
    int          s;
    int          w;
    logic        hold;
    logic [15:0] data;
  } exp_t;

  exp_t        sb[$];
  logic        mon_en = 1'b0;
  logic [15:0] last_data = 16'h0;
  int          en_cnt = 0, st_cnt = 0, wr_bad = 0;

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (dmem_en_o) begin
        en_cnt++;
        if (sb.size() > 0 && dmem_wr_o !== sb[0].wr) wr_bad++;
      end
      if (dmem_done_i && sb.size() > 0) begin
        e = sb.pop_front();
        check("cpl_rdata", int'(rdata_o), int'(e.data));
        check("cpl_stall", int'(stall_o), 0);
        check("cpl_bubble", int'(memwb_bubble_o), int'(e.hold));
        check("stall_cycles", st_cnt, e.s + e.w);
        check("en_cycles", en_cnt, e.s + 1);
        check("wr_dir", wr_bad, 0);
        check("cpl_err", int'(err_o), 0);
        last_data = e.data;
        en_cnt = 0;
        st_cnt = 0;
        wr_bad = 0;
      end else begin
        if (dmem_done_i) check("spurious_rdata", int'(rdata_o), int'(dmem_rdata_i));
        else             check("held_rdata", int'(rdata_o), int'(last_data));
        if (stall_o) st_cnt++;
      end
    end
  end

  task automatic set_in(input logic rd, input logic wr, input logic fl, input logic hd,
                        input logic st, input logic dn, input logic [15:0] rdat);
    mem_read_i   = rd;
    mem_write_i  = wr;
    flush_i      = fl;
    hold_i       = hd;
    dmem_stall_i = st;
    dmem_done_i  = dn;
    dmem_rdata_i = rdat;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected it to finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    int   gap, h;
    logic rd, wr, last;

    rst = 1'b0;
    set_in(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'hFFFF);
    #12;
    check("rst_en", int'(dmem_en_o), 0);
    check("rst_wr", int'(dmem_wr_o), 0);
    check("rst_rdata", int'(rdata_o), 0);
    check("rst_stall", int'(stall_o), 0);
    check("rst_bubble", int'(memwb_bubble_o), 0);
    check("rst_err", int'(err_o), 0);
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    tick;
    rst = 1'b1;
    mon_en = 1'b1;

    for (int n = 0; n < 80; n++) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        rd = 1'($urandom_range(0, 1));
        wr = 1'($urandom_range(0, 1));
        set_in(rd, wr, rd | wr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 3) == 0), 16'($urandom));
        tick;
      end
      e.wr   = 1'($urandom_range(0, 1));
      e.s    = $urandom_range(0, 3);
      e.w    = $urandom_range(0, 6);
      h      = $urandom_range(0, 3);
      e.hold = (h > 0);
      e.data = 16'($urandom);
      sb.push_back(e);
      for (int c = 0; c <= e.s + e.w; c++) begin
        last = (c == e.s + e.w);
        set_in(!e.wr, e.wr ? 1'b1 : 1'($urandom_range(0, 1)), 1'b0, last ? e.hold : 1'b0,
               (c < e.s), last, last ? e.data : 16'($urandom));
        tick;
      end
      for (int k = 1; k < h; k++) begin
        set_in(!e.wr, e.wr, 1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0, 16'($urandom));
        tick;
      end
      if (h > 0) begin
        set_in(!e.wr, e.wr, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0, 16'($urandom));
        tick;
      end
    end
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    repeat (3) tick;
    check("idle_stall_cycles", st_cnt, 0);
    check("idle_en_cycles", en_cnt, 0);
    check("sb_drained", sb.size(), 0);
    mon_en = 1'b0;

    // Flush while the memory is still refusing the request.
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
    @(negedge clk);
    check("req_issue_en", int'(dmem_en_o), 1);
    check("req_issue_stall", int'(stall_o), 1);
    tick;
    set_in(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0);
    @(negedge clk);
    check("flush_req_stall", int'(stall_o), 1);
    tick;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    @(negedge clk);
    check("flush_req_en_drop", int'(dmem_en_o), 0);
    check("flush_req_stall_drop", int'(stall_o), 0);
    check("flush_req_held", int'(rdata_o), int'(last_data));
    tick;

    // Flush after acceptance: the access still completes.
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    @(negedge clk);
    check("wait_issue_en", int'(dmem_en_o), 1);
    tick;
    set_in(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    @(negedge clk);
    check("flush_wait_stall", int'(stall_o), 1);
    check("flush_wait_en", int'(dmem_en_o), 0);
    tick;
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'hA5A5);
    @(negedge clk);
    check("flush_wait_cpl_stall", int'(stall_o), 0);
    check("flush_wait_cpl_rdata", int'(rdata_o), 16'hA5A5);
    tick;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    @(negedge clk);
    check("flush_wait_held", int'(rdata_o), 16'hA5A5);
    tick;

    // Same-cycle completion from idle.
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h00FF);
    @(negedge clk);
    check("same_cycle_stall", int'(stall_o), 0);
    check("same_cycle_bubble", int'(memwb_bubble_o), 0);
    check("same_cycle_en", int'(dmem_en_o), 1);
    check("same_cycle_rdata", int'(rdata_o), 16'h00FF);
    tick;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    @(negedge clk);
    check("same_cycle_held", int'(rdata_o), 16'h00FF);
    tick;

    // Hung memory: error becomes visible TO cycles after the issue cycle.
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    tick;
    for (int c = 1; c <= TO; c++) begin
      @(negedge clk);
      check("pre_timeout_err", int'(err_o), 0);
      check("pre_timeout_stall", int'(stall_o), 1);
      tick;
    end
    @(negedge clk);
    check("timeout_err", int'(err_o), 1);
    tick;
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h5555);
    tick;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    repeat (3) tick;
    @(negedge clk);
    check("err_sticky", int'(err_o), 1);
    check("err_stall", int'(stall_o), 1);
    check("err_no_en", int'(dmem_en_o), 0);
    check("err_held_rdata", int'(rdata_o), 16'h00FF);
    set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
    rst = 1'b0;
    #1;
    check("rst_clears_err", int'(err_o), 0);
    check("rst_clears_stall", int'(stall_o), 0);
    check("rst_clears_bubble", int'(memwb_bubble_o), 0);
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    tick;
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_rdata", int'(rdata_o), 0);
    check("post_rst_err", int'(err_o), 0);
    check("post_rst_stall", int'(stall_o), 0);
    tick;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
